barrel_hazard_ctrl: RTL and testbench
=====================================

# barrel_hazard_ctrl

- Generates the hold (`en`) and clear (`clr`) controls for the fetch/decode and decode/execute pipeline registers of the barrel RISC-V core.
- Keeps a per-thread register scoreboard, so an instruction leaves decode only when its operands are not pending from a long-latency producer of the same thread.
- Squashes younger same-thread instructions when a branch or jump resolves taken in execute.
- Sits beside the decode stage, between the decode outputs and the decode/execute pipeline register.

## Interface
- `BITS_THREADS`, 3: thread-ID width; `2**BITS_THREADS` threads.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_f`  in  1  fetch slot holds a live instruction.
- `tid_f`  in  BITS_THREADS  fetch thread ID.
- `valid_d`  in  1  decode slot holds a live instruction.
- `tid_d`  in  BITS_THREADS  decode thread ID.
- `rs1_d`, `rs2_d`, `rd_d`  in  5 each  decode register indices.
- `use_rs1_d`, `use_rs2_d`  in  1 each  operand is actually read.
- `reg_write_d`  in  1  decode instruction writes `rd_d`.
- `valid_e`  in  1  execute slot live.
- `tid_e`  in  BITS_THREADS  execute thread ID.
- `pc_src_e`  in  1  taken branch or jump resolved in execute.
- `reg_write_w`  in  1  writeback writes a register.
- `tid_w`  in  BITS_THREADS  writeback thread ID.
- `rd_w`  in  5  writeback destination.
- `stall_fd`  out  1  hold the fetch/decode register; drives its `en`.
- `flush_fd`  out  1  clear the fetch/decode register.
- `flush_de`  out  1  clear the decode/execute register; drives its `clr`.
- `issue_d`  out  1  decode instruction advances this cycle.

## Operation
- **State.** One 32-bit busy vector per thread, `busy[t][r]`. Bit 0 is hard-wired to 0.
- **Hazard.** `hz` = `valid_d` AND any of the following, evaluated against `busy[tid_d]` with the same-cycle writeback clear already applied:
  - (`use_rs1_d` AND `busy[rs1_d]`)
  - (`use_rs2_d` AND `busy[rs2_d]`)
  - (`reg_write_d` AND `busy[rd_d]`), the WAW case.
- **Kill.** `kill_d` = `valid_e` AND `pc_src_e` AND `valid_d` AND (`tid_d` == `tid_e`).
- **Fetch kill.** `kill_f` = `valid_e` AND `pc_src_e` AND `valid_f` AND (`tid_f` == `tid_e`).
- **Outputs:**
  - `flush_de` = `kill_d` OR `hz`. A killed or hazarded instruction becomes a bubble in execute.
  - `stall_fd` = `hz` AND NOT `kill_d`.
  - `flush_fd` = `kill_f` AND NOT `stall_fd`.
  - `issue_d` = `valid_d` AND NOT `hz` AND NOT `kill_d`.
- **Set.** On `issue_d` AND `reg_write_d` AND `rd_d` != 0: `busy[tid_d][rd_d]` <= 1.
- **Clear.** On `reg_write_w` AND `rd_w` != 0: `busy[tid_w][rd_w]` <= 0.
- **Same-entry collision.** When set and clear hit the same thread and register in one cycle, set wins.
- **Clear bypass.** A clear is visible to the same-cycle hazard check, so an operand being written back does not stall.
- **Independence.** Threads never interact through the scoreboard. A hazard on one thread stalls the whole decode slot; there is no thread skipping.

## Timing
- Hazard and flush outputs are combinational from inputs and current scoreboard; there is no added latency.
- A scoreboard set is visible to the decode check on the next cycle.
- Minimum stall for a dependent instruction: from issue of the producer until the cycle its writeback asserts. Stall length is fully determined by writeback timing.
- **Reset.** `rst_n` low clears every busy bit asynchronously. While `rst_n` is low, `stall_fd`, `flush_fd`, `flush_de` and `issue_d` are forced to 0. Counters under the macro reset to 0.
- **Reset mid-stall.** Pending busy bits are discarded and the stall drops immediately. Releasing reset needs no extra cycle.
- **Branch kill during a stall.** `kill_d` overrides `hz`: `stall_fd`=0, `flush_de`=1, and no busy bit is set.
- **Writeback clearing the stalling register.** The stall ends in that same cycle and `issue_d`=1.

## Configuration
- Macro: `BARREL_HAZARD_PERF_EN`.
- **Defined:** adds 32-bit outputs `stall_cycles` and `kill_count`.
  - `stall_cycles` increments on every cycle with `stall_fd`=1.
  - `kill_count` increments by `kill_d` + `kill_f` (0..2) per cycle.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- **Not defined:** the ports and counters are absent; functional behaviour is identical.

## Test plan
- **Load-use stall.** Issue tid 2 writing x5 (set), then tid 2 reads x5 on the next decode → `stall_fd`=1 and `flush_de`=1 each cycle until `reg_write_w`, `tid_w`=2, `rd_w`=5; in that cycle `issue_d`=1 and `stall_fd`=0.
- **Thread isolation and x0.** x5 busy for tid 2; tid 3 reads x5 → no stall. Any instruction writing x0 → never sets, never stalls.
- **Branch kill.** `pc_src_e`=1, `tid_e`=4, `tid_d`=4, `tid_f`=4 → `flush_de`=1, `flush_fd`=1, `issue_d`=0, no scoreboard set. With `tid_d`=1 → no `flush_de`.
- **Kill beats stall.** Hazarded decode on tid 0 plus a taken branch on tid 0 in execute → `stall_fd`=0, `flush_de`=1.
- **Set/clear collision.** Issue writes tid 1 x7 while writeback clears tid 1 x7 → x7 busy afterwards; a following reader of x7 stalls.
- **Async reset mid-stall.** Drop `rst_n` between clock edges while stalled → outputs 0 immediately, all busy bits clear, first decode after release issues.

Source files
------------

// File: rtl/barrel_hazard_ctrl.sv
// Per-thread register scoreboard with hold/clear control for the F/D and D/E pipeline registers.
// Zero latency: all outputs are combinational. Hazards hold decode until writeback. BARREL_HAZARD_PERF_EN adds counters.
module barrel_hazard_ctrl #(
   parameter int BITS_THREADS = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_f,
   input  logic [BITS_THREADS-1:0] tid_f,
   input  logic                    valid_d,
   input  logic [BITS_THREADS-1:0] tid_d,
   input  logic [4:0]              rs1_d,
   input  logic [4:0]              rs2_d,
   input  logic [4:0]              rd_d,
   input  logic                    use_rs1_d,
   input  logic                    use_rs2_d,
   input  logic                    reg_write_d,
   input  logic                    valid_e,
   input  logic [BITS_THREADS-1:0] tid_e,
   input  logic                    pc_src_e,
   input  logic                    reg_write_w,
   input  logic [BITS_THREADS-1:0] tid_w,
   input  logic [4:0]              rd_w,
   output logic                    stall_fd,
   output logic                    flush_fd,
   output logic                    flush_de,
   output logic                    issue_d
`ifdef BARREL_HAZARD_PERF_EN
   ,
   output logic [31:0]             stall_cycles,
   output logic [31:0]             kill_count
`endif
);
   localparam int NUM_THREADS = 1 << BITS_THREADS;

   logic [NUM_THREADS-1:0][31:0] busy;
   logic [31:0]                  busy_d;
   logic                         hz;
   logic                         kill_d;
   logic                         kill_f;
   logic                         clr_hit;
   logic                         set_hit;

   assign clr_hit = reg_write_w && (rd_w != 5'd0);

   // Writeback clear is bypassed so an operand retiring this cycle does not stall.
   always_comb begin
      busy_d = busy[tid_d];
      if (clr_hit && (tid_w == tid_d)) busy_d[rd_w] = 1'b0;
      busy_d[0] = 1'b0;
   end

   assign hz = valid_d && ((use_rs1_d && busy_d[rs1_d]) ||
                           (use_rs2_d && busy_d[rs2_d]) ||
                           (reg_write_d && busy_d[rd_d]));

   assign kill_d = valid_e && pc_src_e && valid_d && (tid_d == tid_e);
   assign kill_f = valid_e && pc_src_e && valid_f && (tid_f == tid_e);

   assign stall_fd = rst_n && hz && !kill_d;
   assign flush_fd = rst_n && kill_f && !(hz && !kill_d);
   assign flush_de = rst_n && (kill_d || hz);
   assign issue_d  = rst_n && valid_d && !hz && !kill_d;

   assign set_hit = issue_d && reg_write_d && (rd_d != 5'd0);

   // Set is written last so it wins a same-entry collision with a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         if (clr_hit) busy[tid_w][rd_w] <= 1'b0;
         if (set_hit) busy[tid_d][rd_d] <= 1'b1;
      end
   end

`ifdef BARREL_HAZARD_PERF_EN
   logic [32:0] stall_nxt;
   logic [32:0] kill_nxt;

   assign stall_nxt = {1'b0, stall_cycles} + 33'(stall_fd);
   assign kill_nxt  = {1'b0, kill_count} + 33'(kill_d) + 33'(kill_f);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         kill_count   <= '0;
      end else begin
         stall_cycles <= stall_nxt[32] ? 32'hFFFF_FFFF : stall_nxt[31:0];
         kill_count   <= kill_nxt[32]  ? 32'hFFFF_FFFF : kill_nxt[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_barrel_hazard_ctrl.sv
// Scoreboard bench for barrel_hazard_ctrl: directed scenarios then random traffic against a reference model.
module tb_barrel_hazard_ctrl;
   localparam int BT = 3;
   localparam int NT = 1 << BT;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_f, valid_d, valid_e, pc_src_e;
   logic [BT-1:0] tid_f, tid_d, tid_e, tid_w;
   logic [4:0]    rs1_d, rs2_d, rd_d, rd_w;
   logic          use_rs1_d, use_rs2_d, reg_write_d, reg_write_w;
   logic          stall_fd, flush_fd, flush_de, issue_d;
`ifdef BARREL_HAZARD_PERF_EN
   logic [31:0]   stall_cycles, kill_count;
   logic [31:0]   m_stall, m_kill;
`endif

   barrel_hazard_ctrl #(.BITS_THREADS(BT)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_f(valid_f), .tid_f(tid_f),
      .valid_d(valid_d), .tid_d(tid_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .reg_write_d(reg_write_d),
      .valid_e(valid_e), .tid_e(tid_e), .pc_src_e(pc_src_e),
      .reg_write_w(reg_write_w), .tid_w(tid_w), .rd_w(rd_w),
      .stall_fd(stall_fd), .flush_fd(flush_fd), .flush_de(flush_de), .issue_d(issue_d)
`ifdef BARREL_HAZARD_PERF_EN
      , .stall_cycles(stall_cycles), .kill_count(kill_count)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mbusy [NT];
   logic [3:0]  expq [$];
   string       tagq [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected {stall_fd, flush_fd, flush_de, issue_d} from the reference scoreboard.
   function automatic logic [3:0] model_out();
      logic [31:0] b;
      logic hz, kd, kf, st;
      b = mbusy[tid_d];
      if (reg_write_w && tid_w == tid_d) b[rd_w] = 1'b0;
      b[0] = 1'b0;
      hz = valid_d && ((use_rs1_d && b[rs1_d]) || (use_rs2_d && b[rs2_d]) || (reg_write_d && b[rd_d]));
      kd = valid_e && pc_src_e && valid_d && (tid_d == tid_e);
      kf = valid_e && pc_src_e && valid_f && (tid_f == tid_e);
      st = hz && !kd;
      return {st, kf && !st, kd || hz, valid_d && !hz && !kd};
   endfunction

   task automatic idle();
      valid_f = 0; tid_f = 0; valid_d = 0; tid_d = 0;
      rs1_d = 0; rs2_d = 0; rd_d = 0;
      use_rs1_d = 0; use_rs2_d = 0; reg_write_d = 0;
      valid_e = 0; tid_e = 0; pc_src_e = 0;
      reg_write_w = 0; tid_w = 0; rd_w = 0;
   endtask

   task automatic clear_model();
      for (int t = 0; t < NT; t++) mbusy[t] = '0;
`ifdef BARREL_HAZARD_PERF_EN
      m_stall = 0; m_kill = 0;
`endif
   endtask

   // Entered at posedge+1 with inputs driven; compares at posedge+4, advances one clock.
   task automatic run(input string tag, input logic [3:0] want, input bit directed);
      logic [3:0] em;
      em = model_out();
      expq.push_back(directed ? want : em);
      tagq.push_back(tag);
      #3;
      check_val(tagq.pop_front(), {28'd0, stall_fd, flush_fd, flush_de, issue_d}, {28'd0, expq.pop_front()});
`ifdef BARREL_HAZARD_PERF_EN
      if (em[3] && m_stall != 32'hFFFF_FFFF) m_stall++;
      m_kill += 32'(valid_e && pc_src_e && valid_d && tid_d == tid_e)
              + 32'(valid_e && pc_src_e && valid_f && tid_f == tid_e);
`endif
      @(posedge clk);
      if (reg_write_w && rd_w != 0) mbusy[tid_w][rd_w] = 1'b0;
      if (em[0] && reg_write_d && rd_d != 0) mbusy[tid_d][rd_d] = 1'b1;
      #1;
   endtask

   initial begin
      clear_model();
      idle();
      valid_d = 1; valid_f = 1; valid_e = 1; pc_src_e = 1;
      #2;
      check_val("rst_outputs", {28'd0, stall_fd, flush_fd, flush_de, issue_d}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1;
      idle();

      // Load-use stall on tid 2 / x5, released by writeback
      valid_d = 1; tid_d = 2; rd_d = 5; reg_write_d = 1;
      run("lu_prod", 4'b0001, 1);
      reg_write_d = 0; rd_d = 0; rs1_d = 5; use_rs1_d = 1;
      run("lu_stall1", 4'b1010, 1);
      run("lu_stall2", 4'b1010, 1);
      reg_write_w = 1; tid_w = 2; rd_w = 5;
      run("lu_wb_release", 4'b0001, 1);
      idle();

      // Thread isolation and x0
      valid_d = 1; tid_d = 2; rd_d = 5; reg_write_d = 1;
      run("iso_prod", 4'b0001, 1);
      tid_d = 3; reg_write_d = 0; rd_d = 0; rs1_d = 5; use_rs1_d = 1;
      run("iso_other_tid", 4'b0001, 1);
      use_rs1_d = 0; reg_write_d = 1; rd_d = 0;
      run("x0_write", 4'b0001, 1);
      reg_write_d = 0; use_rs1_d = 1; rs1_d = 0; use_rs2_d = 1; rs2_d = 0;
      run("x0_read", 4'b0001, 1);
      idle();

      // Branch kill on tid 4
      valid_e = 1; pc_src_e = 1; tid_e = 4;
      valid_f = 1; tid_f = 4; valid_d = 1; tid_d = 4; reg_write_d = 1; rd_d = 9;
      run("kill_both", 4'b0110, 1);
      idle();
      valid_d = 1; tid_d = 4; use_rs1_d = 1; rs1_d = 9;
      run("kill_no_set", 4'b0001, 1);
      valid_e = 1; pc_src_e = 1; tid_e = 4; valid_f = 1; tid_f = 4; tid_d = 1;
      run("kill_other_d", 4'b0101, 1);
      idle();

      // Kill beats stall on tid 0
      valid_d = 1; tid_d = 0; reg_write_d = 1; rd_d = 3;
      run("kb_prod", 4'b0001, 1);
      reg_write_d = 0; rd_d = 0; use_rs1_d = 1; rs1_d = 3;
      run("kb_hazard", 4'b1010, 1);
      valid_e = 1; pc_src_e = 1; tid_e = 0; valid_f = 1; tid_f = 0;
      run("kb_kill", 4'b0110, 1);
      idle();

      // Set/clear collision on tid 1 / x7
      valid_d = 1; tid_d = 1; reg_write_d = 1; rd_d = 7;
      reg_write_w = 1; tid_w = 1; rd_w = 7;
      run("coll_issue", 4'b0001, 1);
      idle();
      valid_d = 1; tid_d = 1; use_rs1_d = 1; rs1_d = 7;
      run("coll_stall", 4'b1010, 1);

      // Async reset mid-stall
      #2;
      rst_n = 0;
      #1;
      check_val("rst_mid_outputs", {28'd0, stall_fd, flush_fd, flush_de, issue_d}, 32'd0);
`ifdef BARREL_HAZARD_PERF_EN
      check_val("rst_mid_stall_cnt", stall_cycles, 32'd0);
`endif
      clear_model();
      @(posedge clk); #1;
      rst_n = 1;
      run("rst_release_issue", 4'b0001, 1);
      idle();

      // Random traffic checked against the reference model
      for (int i = 0; i < 400; i++) begin
         valid_f     = 1'($urandom_range(0, 1));
         tid_f       = BT'($urandom_range(0, NT - 1));
         valid_d     = ($urandom_range(0, 9) < 8);
         tid_d       = BT'($urandom_range(0, 3));
         rs1_d       = 5'($urandom_range(0, 3));
         rs2_d       = 5'($urandom_range(0, 3));
         rd_d        = 5'($urandom_range(0, 3));
         use_rs1_d   = 1'($urandom_range(0, 1));
         use_rs2_d   = 1'($urandom_range(0, 1));
         reg_write_d = 1'($urandom_range(0, 1));
         valid_e     = 1'($urandom_range(0, 1));
         tid_e       = BT'($urandom_range(0, 3));
         pc_src_e    = ($urandom_range(0, 9) < 2);
         reg_write_w = ($urandom_range(0, 9) < 3);
         tid_w       = BT'($urandom_range(0, 3));
         rd_w        = 5'($urandom_range(0, 3));
         run("rand", 4'b0000, 0);
      end
      idle();
      #3;
`ifdef BARREL_HAZARD_PERF_EN
      check_val("perf_stall_cycles", stall_cycles, m_stall);
      check_val("perf_kill_count", kill_count, m_kill);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
